// File: rtl/debug_io_buffered_if.sv
// Event stream from the debug I/O buffer to its consumer.
// Head is held on tag/data while out_valid is high; out_ready accepts it.
interface debug_io_buffered_if;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_tag;
    logic [15:0] out_data;

    modport master (output out_valid, output out_tag, output out_data, input out_ready);
    modport slave  (input out_valid, input out_tag, input out_data, output out_ready);
endinterface

// File: rtl/debug_io_buffered.sv
// Debug I/O port: decodes bus writes into print/assert events queued in a FIFO; status/fail readback; sticky /HALT.
// Latency: write seen on out_valid/halt 2 clocks after the sampled /W rise; reads are combinational.
// Backpressure: FIFO absorbs events while out_ready is low; pushes into a full FIFO are dropped and flag ovf.
// Optional DEBUG_IO_BUFFERED_TRACE_EN prints each popped event and halt/assert events.
module debug_io_buffered #(
    parameter int         DEPTH       = 16,
    parameter logic [9:0] STATUS_ADDR = 10'h3f0,
    parameter logic [9:0] FAILS_ADDR  = 10'h3f7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 abus,
    inout  wire  [15:0]                 dbus,
    input  logic                        io,
    input  logic                        r,
    input  logic                        w,
    output logic                        halt,
    debug_io_buffered_if.master         stream,
    output logic [7:0]                  fail_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] dat;
    } evt_t;

    logic        io_q, w_q, r_q, io_qq, w_qq, r_qq;
    logic [9:0]  addr_q, addr_qq;
    logic [15:0] data_q, data_qq;

    // Two sample stages: the older one supplies address/data for the strobe edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_q    <= 1'b1;
            w_q     <= 1'b1;
            r_q     <= 1'b1;
            io_qq   <= 1'b1;
            w_qq    <= 1'b1;
            r_qq    <= 1'b1;
            addr_q  <= '0;
            addr_qq <= '0;
            data_q  <= '0;
            data_qq <= '0;
        end else begin
            io_q    <= io;
            w_q     <= w;
            r_q     <= r;
            addr_q  <= abus[9:0];
            data_q  <= dbus;
            io_qq   <= io_q;
            w_qq    <= w_q;
            r_qq    <= r_q;
            addr_qq <= addr_q;
            data_qq <= data_q;
        end
    end

    logic wr_evt, rd_evt;
    assign wr_evt = w_q && !w_qq && !io_qq;
    assign rd_evt = r_q && !r_qq && !io_qq;

    logic push_req, do_halt, do_fail;
    evt_t push_evt;

    always_comb begin
        push_req = 1'b0;
        push_evt = '0;
        do_halt  = 1'b0;
        do_fail  = 1'b0;
        if (wr_evt) begin
            case (addr_qq)
                10'h007: do_halt = 1'b1;
                10'h3f1: begin push_req = 1'b1; push_evt = '{tag: 3'd1, dat: data_qq}; end
                10'h3f2: begin push_req = 1'b1; push_evt = '{tag: 3'd2, dat: data_qq}; end
                10'h3f3: begin push_req = 1'b1; push_evt = '{tag: 3'd3, dat: data_qq}; end
                10'h3f4: begin push_req = 1'b1; push_evt = '{tag: 3'd4, dat: data_qq}; end
                10'h3f5: begin push_req = 1'b1; push_evt = '{tag: 3'd1, dat: 16'd32}; end
                10'h3f6: begin push_req = 1'b1; push_evt = '{tag: 3'd1, dat: 16'd10}; end
                10'h3fe: ;
                10'h3ff: begin do_fail = 1'b1; do_halt = 1'b1; end
                default: begin push_req = 1'b1; push_evt = '{tag: 3'd7, dat: data_qq}; end
            endcase
        end
    end

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, full, empty, pop, push_ok;
    evt_t          head;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && stream.out_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push_req && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            halt       <= 1'b1;
            fail_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && full && !pop)
                ovf <= 1'b1;
            else if (rd_evt && addr_qq == STATUS_ADDR)
                ovf <= 1'b0;
            if (do_halt) halt <= 1'b0;
            if (do_fail && fail_count != 8'hff) fail_count <= fail_count + 1'b1;
        end
    end

    assign stream.out_valid = !empty;
    assign stream.out_tag   = empty ? 3'd0 : head.tag;
    assign stream.out_data  = empty ? 16'd0 : head.dat;

    logic [7:0]  count8;
    logic [15:0] rd_dat;
    assign count8 = 8'(count);

    always_comb begin
        case (abus[9:0])
            STATUS_ADDR: rd_dat = {full, empty, ovf, 5'b0, count8};
            FAILS_ADDR:  rd_dat = {8'b0, fail_count};
            default:     rd_dat = 16'hbeef;
        endcase
    end

    assign dbus = (!io && !r) ? rd_dat : 16'hzzzz;

    logic unused_abus;
    assign unused_abus = &{1'b0, abus[15:10]};

`ifdef DEBUG_IO_BUFFERED_TRACE_EN
    logic [9:0] trace_addr [DEPTH];

    always_ff @(posedge clk) begin
        if (push_ok) trace_addr[wr_ptr] <= addr_qq;
        if (pop) begin
            case (head.tag)
                3'd1:    $display("D: PRINTC %c", head.dat[7:0]);
                3'd2:    $display("D: PRINTD %0d", $signed(head.dat));
                3'd3:    $display("D: PRINTH %04h", head.dat);
                3'd4:    $display("D: PRINTB %016b", head.dat);
                3'd7:    $display("D: io[%03h] <- %04h", trace_addr[rd_ptr], head.dat);
                default: $display("D: PRINTU %0d", head.dat);
            endcase
        end
        if (wr_evt && addr_qq == 10'h3ff) $display("D: ASSERT: FALSE");
        if (do_halt) $display("D: *** HALTING ***");
    end
`else
    // Synthesis build: events leave only through the output stream.
`endif

endmodule

// File: tb/tb_debug_io_buffered.sv
// Scoreboard bench for debug_io_buffered: expected events are queued at issue, a monitor checks each pop.
module tb_debug_io_buffered;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] abus;
    wire  [15:0] dbus;
    logic        io, r, w;
    logic        halt;
    logic [7:0]  fail_count;
    logic        tb_drv;
    logic [15:0] tb_dat;

    debug_io_buffered_if stream_if ();

    debug_io_buffered dut (
        .clk        (clk),
        .reset      (reset),
        .abus       (abus),
        .dbus       (dbus),
        .io         (io),
        .r          (r),
        .w          (w),
        .halt       (halt),
        .stream     (stream_if),
        .fail_count (fail_count)
    );

    assign dbus = tb_drv ? tb_dat : 16'hzzzz;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (reset && stream_if.out_valid && stream_if.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h, expected none", {stream_if.out_tag, stream_if.out_data});
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({stream_if.out_tag, stream_if.out_data} !== e) begin
                    n_fail++;
                    $display("FAIL pop_event: got %h, expected %h", {stream_if.out_tag, stream_if.out_data}, e);
                end
            end
        end
    end

    task automatic io_write(input logic [9:0] a, input logic [15:0] d, input bit pop_at_push);
        abus = {6'b0, a}; tb_dat = d; tb_drv = 1'b1; io = 1'b0; w = 1'b0;
        repeat (3) @(posedge clk);
        #1 w = 1'b1;
        @(posedge clk); #1;
        io = 1'b1; tb_drv = 1'b0;
        if (pop_at_push) stream_if.out_ready = 1'b1;
        @(posedge clk); #1;
        if (pop_at_push) stream_if.out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic io_read(input logic [9:0] a, output logic [15:0] d);
        abus = {6'b0, a}; io = 1'b0; r = 1'b0;
        repeat (2) @(posedge clk);
        #1 d = dbus;
        r = 1'b1;
        @(posedge clk); #1;
        io = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got no finish, expected finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        reset = 1'b0; abus = '0; io = 1'b1; r = 1'b1; w = 1'b1;
        tb_drv = 1'b0; tb_dat = '0; stream_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        check("rst_out_valid", 32'(stream_if.out_valid), 32'd0);
        check("rst_out_tag", 32'(stream_if.out_tag), 32'd0);
        check("rst_out_data", 32'(stream_if.out_data), 32'd0);
        check("rst_halt", 32'(halt), 32'd1);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        io_read(10'h3f0, rd); check("rst_status", 32'(rd), 32'h4000);
        io_read(10'h3f7, rd); check("rst_fails", 32'(rd), 32'h0000);
        io_read(10'h123, rd); check("unmapped_read", 32'(rd), 32'hbeef);

        // Char write held in the FIFO, then drained
        exp_q.push_back({3'd1, 16'h0041});
        io_write(10'h3f1, 16'h0041, 1'b0);
        check("char_valid", 32'(stream_if.out_valid), 32'd1);
        check("char_tag", 32'(stream_if.out_tag), 32'd1);
        check("char_data", 32'(stream_if.out_data), 32'h0041);
        io_read(10'h3f0, rd); check("char_status", 32'(rd), 32'h0001);
        stream_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 stream_if.out_ready = 1'b0;
        check("char_drained", 32'(stream_if.out_valid), 32'd0);

        // Overflow: 17 pushes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({3'd2, 16'(i)});
            io_write(10'h3f2, 16'(i), 1'b0);
        end
        io_read(10'h3f0, rd); check("ovf_status", 32'(rd), 32'ha010);
        io_read(10'h3f0, rd); check("ovf_cleared", 32'(rd), 32'h8010);

        // Push and pop in the same cycle while full
        exp_q.push_back({3'd4, 16'hb0b0});
        io_write(10'h3f4, 16'hb0b0, 1'b1);
        io_read(10'h3f0, rd); check("full_pushpop_status", 32'(rd), 32'h8010);
        stream_if.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("full_drained_valid", 32'(stream_if.out_valid), 32'd0);
        check("full_drained_queue", 32'(exp_q.size()), 32'd0);

        // Drain order with consumer always ready
        exp_q.push_back({3'd3, 16'h1234}); io_write(10'h3f3, 16'h1234, 1'b0);
        exp_q.push_back({3'd1, 16'h000a}); io_write(10'h3f6, 16'h0000, 1'b0);
        exp_q.push_back({3'd1, 16'h0020}); io_write(10'h3f5, 16'h7777, 1'b0);
        io_write(10'h3fe, 16'h9999, 1'b0);
        exp_q.push_back({3'd7, 16'h5555}); io_write(10'h100, 16'h5555, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("order_valid", 32'(stream_if.out_valid), 32'd0);
        check("order_queue", 32'(exp_q.size()), 32'd0);
        check("order_halt", 32'(halt), 32'd1);
        stream_if.out_ready = 1'b0;

        // Assertion failures saturate at 255 and halt
        io_write(10'h3ff, 16'h0000, 1'b0);
        check("assert_halt", 32'(halt), 32'd0);
        check("assert_count1", 32'(fail_count), 32'd1);
        for (int i = 1; i < 300; i++) io_write(10'h3ff, 16'h0000, 1'b0);
        check("assert_sat", 32'(fail_count), 32'd255);
        io_read(10'h3f7, rd); check("fails_read", 32'(rd), 32'h00ff);
        check("assert_no_push", 32'(stream_if.out_valid), 32'd0);

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'd2, 16'(100 + i)});
            io_write(10'h3f2, 16'(100 + i), 1'b0);
        end
        abus = 16'h03f1; tb_dat = 16'h00aa; tb_drv = 1'b1; io = 1'b0; w = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        #3;
        check("midrst_valid", 32'(stream_if.out_valid), 32'd0);
        check("midrst_halt", 32'(halt), 32'd1);
        w = 1'b1; io = 1'b1; tb_drv = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_valid_after", 32'(stream_if.out_valid), 32'd0);
        check("midrst_fail_count", 32'(fail_count), 32'd0);
        io_read(10'h3f0, rd); check("midrst_status", 32'(rd), 32'h4000);

        io_write(10'h007, 16'h0000, 1'b0);
        check("halt_007", 32'(halt), 32'd0);
        check("halt_007_no_push", 32'(stream_if.out_valid), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_io_buffered.md
# debug_io_buffered

Clocked, parametrised successor to the simulation debug I/O port. It decodes CPU I/O writes in the debug window and queues print and assert events in a FIFO. Queued events drain through a valid/ready output stream, and the bus can read back status and failure counters. It sits on the I/O bus alongside real peripherals in testbenches and FPGA debug builds, and drives the active-low halt line.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..128.
- `STATUS_ADDR`, 10'h3f0: I/O offset of the read-only status register.
- `FAILS_ADDR`, 10'h3f7: I/O offset of the read-only fail counter.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `abus` in 16: address bus; only bits [9:0] are decoded.
- `dbus` inout 16: data bus; driven only during a decoded I/O read, else `z`.
- `io` in 1: /IO, active low.
- `r` in 1: /R, active low.
- `w` in 1: /W, active low.
- `halt` out 1: /HALT, active low, sticky.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_tag` out 3: event kind. 1=char, 2=dec, 3=hex, 4=bin, 7=raw.
- `out_data` out 16: event payload.
- `fail_count` out 8: saturating count of false assertions.

## Operation
- **Bus sampling**
  - `io`, `w`, `r`, `abus[9:0]` and `dbus` are registered every clock.
  - A write event fires on the clock where sampled `w` goes 0→1 and the previous sample had `io`=0.
  - The event uses the address and data from the previous sample.
- **Write decode (offset = addr[9:0])**
  - 007: `halt`←0.
  - 3f1: push {1, data}.
  - 3f2: push {2, data}.
  - 3f3: push {3, data}.
  - 3f4: push {4, data}.
  - 3f5: push {1, 16'd32}.
  - 3f6: push {1, 16'd10}.
  - 3fe: no effect.
  - 3ff: `fail_count`+1, saturating at 255; `halt`←0.
  - Any other offset: push {7, data}.
- **FIFO**
  - `count` spans 0..DEPTH.
  - `out_valid` = (count != 0); head is presented on `out_tag`/`out_data`.
  - A pop occurs when `out_valid` && `out_ready`.
  - Push when full is dropped and sets sticky `ovf`.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Read/write pointers wrap modulo DEPTH.
- **Halt**
  - `halt` stays asserted until reset.
  - The FIFO continues to accept and drain events while halted.
- **Reads** (combinational while `io`=0 and `r`=0)
  - STATUS_ADDR: {full, empty, ovf, 5'b0, count[7:0]}.
  - FAILS_ADDR: {8'b0, fail_count}.
  - Any other offset: 16'hbeef.
- A status read clears `ovf` on the clock where sampled `r` goes 0→1 with `io` low.

## Timing
- **Reset values:** `halt`=1, `out_valid`=0, `out_tag`=0, `out_data`=0, `fail_count`=0, `ovf`=0, pointers=0, `dbus`=z.
- **Strobe width:** `w` and `r` low pulses must span ≥2 clocks. Shorter pulses may be missed.
- **Write-to-effect:** detection occurs ≤2 clocks after `w` rises. `out_valid`/`halt` update on the clock edge after detection.
- **Reset mid-operation:** FIFO is emptied immediately, in-flight events are lost, and `halt` deasserts.

## Configuration
- `DEBUG_IO_BUFFERED_TRACE_EN` defined:
  - Every pop `$display`s in the legacy formats: `D: PRINTC`, `PRINTD`, `PRINTH`, `PRINTB`, `PRINTU`, plus `io[...] <- ...` for raw.
  - Halt and assert-false print `D: *** HALTING ***` and `D: ASSERT: FALSE` at detection.
- Undefined: no simulation output; the block is fully synthesisable.

## Test plan
- **Reset:** assert `reset`=0 mid-burst → `out_valid`=0, `halt`=1, `fail_count`=0, status read = 16'h4000.
- **Char write:** write 16'h0041 to 3f1 with `out_ready`=0 → `out_valid`=1, `out_tag`=1, `out_data`=16'h0041; status count=1.
- **Overflow:** DEPTH=16, 17 writes to 3f2 with `out_ready`=0.
  - Status = 16'hA010 (full, ovf, count 16).
  - A second status read returns 16'h8010.
- **Drain order:** push 3f3←16'h1234 then 3f6, with `out_ready`=1 → pops {3,1234} then {1,000a}; afterwards `out_valid`=0.
- **Assertions:** 300 writes to 3ff → `fail_count`=255 (saturates); `halt`=0 after the first write; FAILS_ADDR read = 16'h00ff.
- **Full push/pop:** full FIFO with `out_ready`=1 while writing 3f4 → count stays 16, no overflow.
